// File: rtl/iu8_decimal_entry_pkg.sv
// Shared types and constants for the decimal entry unit: FSM states, signed range limits,
// key indices and the BCD-to-binary magnitude helper.
package iu8_decimal_entry_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StEntry = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam int unsigned PosLimit = 127;
  localparam int unsigned NegLimit = 128;

  localparam int unsigned NumKeys  = 5;
  localparam int unsigned KeyDigit = 0;
  localparam int unsigned KeyNeg   = 1;
  localparam int unsigned KeyDel   = 2;
  localparam int unsigned KeyClr   = 3;
  localparam int unsigned KeyEnter = 4;

  function automatic logic [7:0] bcd_mag(input logic [3:0] h, input logic [3:0] t,
                                         input logic [3:0] o);
    logic [11:0] m;
    m = {8'd0, h} * 12'd100 + {8'd0, t} * 12'd10 + {8'd0, o};
    return m[7:0];
  endfunction

endpackage

// File: rtl/iu8_decimal_entry_key_conditioner.sv
// One push-button: 2-flop synchroniser, debounce counter and a registered rising-edge press pulse.
// Press pulse appears DB_CYCLES+3 cycles after a stable raw edge.
module iu8_decimal_entry_key_conditioner #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic press_o
);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            prev_q, prev_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = key_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    prev_d  = level_q;
    press_d = level_q & ~prev_q;
  end

  // Reset assumes the key is pressed, so a key held through reset must be released
  // and pressed again before it produces a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/iu8_decimal_entry.sv
// Decimal keypad entry of a signed 8-bit operand: BCD digit store, sign, range checking and a
// valid/ready hand-off of the committed value.
module iu8_decimal_entry
  import iu8_decimal_entry_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_sw,
  input  logic       key_digit,
  input  logic       key_neg,
  input  logic       key_del,
  input  logic       key_clr,
  input  logic       key_enter,
  input  logic       x_ready,
  output logic [7:0] x_out,
  output logic       x_valid,
  output logic [7:0] x_live,
  output logic [1:0] ndigits,
  output logic       err
);

  logic [NumKeys-1:0] raw, press;

  assign raw[KeyDigit] = key_digit;
  assign raw[KeyNeg]   = key_neg;
  assign raw[KeyDel]   = key_del;
  assign raw[KeyClr]   = key_clr;
  assign raw[KeyEnter] = key_enter;

  for (genvar k = 0; k < NumKeys; k++) begin : g_key
    iu8_decimal_entry_key_conditioner #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_cond (
      .clk    (clk),
      .reset  (reset),
      .key_i  (raw[k]),
      .press_o(press[k])
    );
  end

  state_e      state_q, state_d;
  logic [3:0]  h_q, h_d, t_q, t_d, o_q, o_d;
  logic        neg_q, neg_d;
  logic [1:0]  ndig_q, ndig_d;
  logic [7:0]  x_out_q, x_out_d;
  logic        x_valid_q, x_valid_d;
  logic [7:0]  x_live_q, x_live_d;
  logic        err_q, err_d;

  logic [7:0]  mag, live;
  logic [11:0] limit, cand;
  logic        in_hold;

  always_comb begin
    mag     = bcd_mag(h_q, t_q, o_q);
    live    = neg_q ? (~mag + 8'd1) : mag;
    limit   = neg_q ? 12'(NegLimit) : 12'(PosLimit);
    cand    = {4'd0, mag} * 12'd10 + {8'd0, digit_sw};
    in_hold = (state_q == StHold);

    state_d   = state_q;
    h_d       = h_q;
    t_d       = t_q;
    o_d       = o_q;
    neg_d     = neg_q;
    ndig_d    = ndig_q;
    x_out_d   = x_out_q;
    x_valid_d = x_valid_q;
    x_live_d  = live;
    err_d     = 1'b0;

    if (in_hold && x_valid_q && x_ready) begin
      x_valid_d = 1'b0;
      state_d   = StEmpty;
    end

    // Only the highest-priority press acts; the rest are silently dropped.
    if (press[KeyClr]) begin
      {h_d, t_d, o_d} = '0;
      neg_d     = 1'b0;
      ndig_d    = '0;
      x_valid_d = 1'b0;
      state_d   = StEmpty;
    end else if (press[KeyEnter]) begin
      if (in_hold) begin
        err_d = 1'b1;
      end else begin
        x_out_d         = live;
        x_valid_d       = 1'b1;
        state_d         = StHold;
        {h_d, t_d, o_d} = '0;
        neg_d           = 1'b0;
        ndig_d          = '0;
      end
    end else if (press[KeyDel]) begin
      if (in_hold || ndig_q == 2'd0) begin
        err_d = 1'b1;
      end else begin
        {h_d, t_d, o_d} = {4'd0, h_q, t_q};
        ndig_d          = ndig_q - 2'd1;
        if (ndig_q == 2'd1) state_d = StEmpty;
      end
    end else if (press[KeyNeg]) begin
      // Flipping -128 to positive would need +128, which does not fit.
      if (in_hold || (neg_q && mag == 8'd128)) begin
        err_d = 1'b1;
      end else begin
        neg_d = ~neg_q;
      end
    end else if (press[KeyDigit]) begin
      if (in_hold || digit_sw > 4'd9 || ndig_q == 2'd3 || cand > limit) begin
        err_d = 1'b1;
      end else begin
        {h_d, t_d, o_d} = {t_q, o_q, digit_sw};
        ndig_d          = ndig_q + 2'd1;
        state_d         = StEntry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      h_q       <= '0;
      t_q       <= '0;
      o_q       <= '0;
      neg_q     <= 1'b0;
      ndig_q    <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      x_live_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      t_q       <= t_d;
      o_q       <= o_d;
      neg_q     <= neg_d;
      ndig_q    <= ndig_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      x_live_q  <= x_live_d;
      err_q     <= err_d;
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign x_live  = x_live_q;
  assign ndigits = ndig_q;
  assign err     = err_q;

endmodule

// File: tb/tb_iu8_decimal_entry.sv
// Directed bench for iu8_decimal_entry with short debounce; committed operands are checked
// against a queue of expected values filled when enter is pressed.
module tb_iu8_decimal_entry;
  import iu8_decimal_entry_pkg::*;

  localparam int unsigned DbCycles = 4;
  localparam int          HoldCyc  = DbCycles + 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_sw;
  logic [4:0] keys;
  logic       x_ready;
  logic [7:0] x_out, x_live;
  logic       x_valid, err;
  logic [1:0] ndigits;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int valid_cycles = 0;
  int sb[$];

  always #5 clk = ~clk;

  iu8_decimal_entry #(
    .DB_CYCLES(DbCycles),
    .DB_W     (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digit_sw (digit_sw),
    .key_digit(keys[KeyDigit]),
    .key_neg  (keys[KeyNeg]),
    .key_del  (keys[KeyDel]),
    .key_clr  (keys[KeyClr]),
    .key_enter(keys[KeyEnter]),
    .x_ready  (x_ready),
    .x_out    (x_out),
    .x_valid  (x_valid),
    .x_live   (x_live),
    .ndigits  (ndigits),
    .err      (err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (x_valid === 1'b1) valid_cycles++;
    if (x_valid === 1'b1 && x_ready === 1'b1) begin
      if (sb.size() == 0) check("sb_unexpected_commit", int'(x_out), -1);
      else check("x_out_commit", int'(x_out), sb.pop_front());
    end
  end

  task automatic press(input logic [4:0] mask, input logic [3:0] sw, input int exp_err,
                       input string tag);
    int e0;
    e0       = err_cnt;
    digit_sw = sw;
    keys     = mask;
    repeat (HoldCyc) @(negedge clk);
    keys = '0;
    repeat (HoldCyc) @(negedge clk);
    check({tag, "_err"}, err_cnt - e0, exp_err);
  endtask

  localparam logic [4:0] MDig = 5'b00001, MNeg = 5'b00010, MDel = 5'b00100,
                         MClr = 5'b01000, MEnt = 5'b10000;

  initial begin
    int v0;
    reset = 1'b1; keys = '0; digit_sw = '0; x_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x_out", int'(x_out), 0);
    check("rst_x_valid", int'(x_valid), 0);
    check("rst_x_live", int'(x_live), 0);
    check("rst_ndigits", int'(ndigits), 0);
    check("rst_err", int'(err), 0);
    reset = 1'b0;
    repeat (HoldCyc) @(negedge clk);
    check("post_rst_no_err", err_cnt, 0);

    // 1: +127 committed, consumer ready.
    press(MDig, 4'd1, 0, "t1_d1");
    press(MDig, 4'd2, 0, "t1_d2");
    press(MDig, 4'd7, 0, "t1_d7");
    check("t1_live", int'(x_live), 8'h7F);
    check("t1_ndig", int'(ndigits), 3);
    v0 = valid_cycles;
    sb.push_back(8'h7F);
    press(MEnt, 4'd0, 0, "t1_enter");
    check("t1_valid_cycles", valid_cycles - v0, 1);
    check("t1_live_cleared", int'(x_live), 0);

    // 2: -128, then sign flip at -128 is rejected.
    press(MNeg, 4'd0, 0, "t2_neg");
    press(MDig, 4'd1, 0, "t2_d1");
    press(MDig, 4'd2, 0, "t2_d2");
    press(MDig, 4'd8, 0, "t2_d8");
    check("t2_live", int'(x_live), 8'h80);
    press(MNeg, 4'd0, 1, "t2_neg_rej");
    check("t2_live_kept", int'(x_live), 8'h80);
    sb.push_back(8'h80);
    press(MEnt, 4'd0, 0, "t2_enter");

    // 3: range overflow, delete, leading zeros, digit count limit, bad BCD, del when empty.
    press(MDig, 4'd1, 0, "t3_d1");
    press(MDig, 4'd2, 0, "t3_d2");
    press(MDig, 4'd9, 1, "t3_d9_rej");
    check("t3_live_12", int'(x_live), 8'h0C);
    press(MDel, 4'd0, 0, "t3_del");
    check("t3_live_1", int'(x_live), 8'h01);
    check("t3_ndig_1", int'(ndigits), 1);
    press(MClr, 4'd0, 0, "t3_clr");
    press(MDig, 4'd0, 0, "t3_d0a");
    press(MDig, 4'd0, 0, "t3_d0b");
    press(MDig, 4'd7, 0, "t3_d7");
    press(MDig, 4'd5, 1, "t3_d5_rej");
    check("t3_live_7", int'(x_live), 8'h07);
    check("t3_ndig_3", int'(ndigits), 3);
    press(MClr, 4'd0, 0, "t3_clr2");
    press(MDig, 4'd10, 1, "t3_bcd_rej");
    press(MDel, 4'd0, 1, "t3_del_empty");
    check("t3_ndig_0", int'(ndigits), 0);

    // 4: bouncing digit key yields exactly one digit.
    v0 = err_cnt;
    digit_sw = 4'd3;
    for (int i = 0; i < 6; i++) begin
      keys[KeyDigit] = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    keys[KeyDigit] = 1'b1;
    repeat (HoldCyc) @(negedge clk);
    keys = '0;
    repeat (HoldCyc) @(negedge clk);
    check("t4_ndig", int'(ndigits), 1);
    check("t4_live", int'(x_live), 3);
    check("t4_err", err_cnt - v0, 0);

    // 5: HOLD with consumer stalled.
    press(MClr, 4'd0, 0, "t5_clr0");
    press(MDig, 4'd5, 0, "t5_d5");
    x_ready = 1'b0;
    sb.push_back(5);
    press(MEnt, 4'd0, 0, "t5_enter");
    check("t5_x_out", int'(x_out), 5);
    check("t5_x_valid", int'(x_valid), 1);
    press(MDig, 4'd2, 1, "t5_digit_hold");
    check("t5_x_out_stable", int'(x_out), 5);
    press(MClr, 4'd0, 0, "t5_clr");
    check("t5_valid_dropped", int'(x_valid), 0);
    check("t5_x_out_kept", int'(x_out), 5);
    check("t5_pending", sb.size(), 1);
    sb.delete();
    x_ready = 1'b1;
    press(MDig, 4'd4, 0, "t5_empty_again");
    check("t5_ndig_after", int'(ndigits), 1);

    // 6: clr beats a simultaneous digit; reset mid-entry; key held through reset.
    press(MClr | MDig, 4'd6, 0, "t6_clr_dig");
    check("t6_ndig", int'(ndigits), 0);
    check("t6_live", int'(x_live), 0);
    press(MDig, 4'd2, 0, "t6_d2");
    press(MDig, 4'd3, 0, "t6_d3");
    press(MNeg, 4'd0, 0, "t6_neg");
    check("t6_live_m23", int'(x_live), 8'hE9);
    reset = 1'b1;
    keys[KeyDigit] = 1'b1;
    digit_sw = 4'd1;
    @(negedge clk);
    check("t6_rst_live", int'(x_live), 0);
    check("t6_rst_ndig", int'(ndigits), 0);
    reset = 1'b0;
    repeat (HoldCyc) @(negedge clk);
    check("t6_held_no_digit", int'(ndigits), 0);
    keys = '0;
    repeat (HoldCyc) @(negedge clk);
    press(MDig, 4'd1, 0, "t6_repress");
    check("t6_repress_ndig", int'(ndigits), 1);
    check("t6_repress_live", int'(x_live), 1);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
